// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, mouse command/response
// bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INHIBIT = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_ACK     = 2'd3
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and PS/2 line signals of the host transmitter.
// master = command issuer / line front end, slave = ps2_host_tx.
interface ps2_host_tx_if;

  logic       i_start;
  logic [7:0] i_data;
  logic       i_ps2_clk_neg;
  logic       i_ps2_data;
  logic       o_ps2_clk_oe;
  logic       o_ps2_data_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_ok;
  logic       o_err;

  modport master (
    output i_start, i_data, i_ps2_clk_neg, i_ps2_data,
    input  o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_ack_ok, o_err
  );

  modport slave (
    input  i_start, i_data, i_ps2_clk_neg, i_ps2_data,
    output o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_ack_ok, o_err
  );

endinterface

// File: rtl/ps2_tx_timer.sv
// Loadable down-counter with a registered zero flag; load wins over count,
// and the count holds at zero.
module ps2_tx_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             zero_r;

  // Next count: reload, decrement while enabled and non-zero, else hold.
  always_comb begin
    count_nxt_s = count_r;
    if (i_load) begin
      count_nxt_s = i_load_val;
    end else if (i_en && (count_r != {WIDTH{1'b0}})) begin
      count_nxt_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register and zero flag, both taken from the same next value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_r <= {WIDTH{1'b0}};
      zero_r  <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      zero_r  <= (count_nxt_s == {WIDTH{1'b0}});
    end
  end

  assign o_zero = zero_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame on device
// clock edges, ACK check. Define PS2_TX_TIMEOUT_EN to enable the edge watchdog.
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic           i_clk,
  input logic           i_rst,
  ps2_host_tx_if.slave  bus
);

  // One counter width covers both the inhibit and the watchdog spans.
  localparam int CNT_W = $clog2(((INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                 INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LOAD_C = CNT_W'(INHIBIT_CYCLES - 1);

  ps2_tx_state_e state_r;
  logic [9:0]    shift_r;
  logic [3:0]    bit_cnt_r;
  logic          clk_oe_r;
  logic          data_oe_r;
  logic          busy_r;
  logic          done_r;
  logic          ack_ok_r;
  logic          err_r;

  logic          inh_load_s;
  logic          inh_en_s;
  logic          inh_zero_s;
  logic          wd_zero_s;

  assign inh_load_s = (state_r == ST_IDLE) & bus.i_start;
  assign inh_en_s   = (state_r == ST_INHIBIT);

  ps2_tx_timer #(.WIDTH(CNT_W)) u_inh_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (inh_load_s),
    .i_load_val (INH_LOAD_C),
    .i_en       (inh_en_s),
    .o_zero     (inh_zero_s)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LOAD_C = CNT_W'(TIMEOUT_CYCLES - 1);

  logic wd_load_s;
  logic wd_en_s;

  // Re-armed by every device edge and by the INHIBIT->SHIFT hand-over.
  assign wd_load_s = bus.i_ps2_clk_neg | ((state_r == ST_INHIBIT) & data_oe_r);
  assign wd_en_s   = (state_r == ST_SHIFT) | (state_r == ST_ACK);

  ps2_tx_timer #(.WIDTH(CNT_W)) u_wd_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (wd_load_s),
    .i_load_val (WD_LOAD_C),
    .i_en       (wd_en_s),
    .o_zero     (wd_zero_s)
  );
`else
  assign wd_zero_s = 1'b0;
`endif

  // Transmit sequencer; every bus output is a register of this block.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= 10'd0;
      bit_cnt_r <= 4'd0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_ok_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start) begin
            // Frame after the start bit: data LSB first, parity, stop.
            shift_r   <= {1'b1, odd_parity(bus.i_data), bus.i_data};
            bit_cnt_r <= 4'd0;
            clk_oe_r  <= 1'b1;
            busy_r    <= 1'b1;
            ack_ok_r  <= 1'b0;
            state_r   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (data_oe_r) begin
            clk_oe_r <= 1'b0;
            state_r  <= ST_SHIFT;
          end else if (inh_zero_s) begin
            data_oe_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.i_ps2_clk_neg) begin
            data_oe_r <= ~shift_r[0];
            shift_r   <= {1'b0, shift_r[9:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd9) begin
              state_r <= ST_ACK;
            end
          end else if (wd_zero_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (bus.i_ps2_clk_neg) begin
            ack_ok_r <= ~bus.i_ps2_data;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (wd_zero_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ps2_clk_oe  = clk_oe_r;
  assign bus.o_ps2_data_oe = data_oe_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_done        = done_r;
  assign bus.o_ack_ok      = ack_ok_r;
  assign bus.o_err         = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a frame-level reference model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 8;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Expected data_oe after device edge k (1..10) when sending byte d.
  function automatic logic exp_oe(input logic [7:0] d, input int k);
    logic b;
    if (k <= 8) b = d[k-1];
    else if (k == 9) b = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    else b = 1'b1;
    return ~b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic pulse_edge(input logic dline);
    bus.i_ps2_data    = dline;
    bus.i_ps2_clk_neg = 1'b1;
    tick();
    bus.i_ps2_clk_neg = 1'b0;
    bus.i_ps2_data    = 1'b1;
  endtask

  task automatic issue_start(input logic [7:0] d);
    bus.i_start = 1'b1;
    bus.i_data  = d;
    tick();
    bus.i_start = 1'b0;
    bus.i_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 2'b00) begin
      errors++; $display("FAIL reset_lines: got %b required 00", {bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_ack_ok, bus.o_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b required 0000", {bus.o_busy, bus.o_done, bus.o_ack_ok, bus.o_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_send_enable();
    logic [9:0] vec;
    vec = 10'b0100001011;
    issue_start(PS2_CMD_ENABLE);
    for (int j = 1; j <= 10; j++) begin
      if (j > 1) tick();
      checks++;
      if (bus.o_ps2_clk_oe !== (j <= 9) || bus.o_ps2_data_oe !== (j >= 9) || bus.o_busy !== 1'b1) begin
        errors++; $display("FAIL enable_inhibit cycle %0d: clk_oe=%b data_oe=%b busy=%b", j, bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      gap();
      pulse_edge(1'b1);
      checks++;
      if (bus.o_ps2_data_oe !== vec[k-1] || bus.o_ps2_clk_oe !== 1'b0) begin
        errors++; $display("FAIL enable_bit edge %0d: data_oe=%b required %b", k, bus.o_ps2_data_oe, vec[k-1]);
      end
    end
    gap();
    pulse_edge(1'b0);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_ack_ok !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL enable_ack: done=%b ack_ok=%b busy=%b required 1 1 0", bus.o_done, bus.o_ack_ok, bus.o_busy);
    end
    tick();
    checks++;
    if (bus.o_done !== 1'b0) begin
      errors++; $display("FAIL enable_done_pulse: done=%b required 0", bus.o_done);
    end
  endtask

  task automatic test_send_reset_nack();
    issue_start(PS2_CMD_RESET);
    repeat (8) tick();
    checks++;
    if (bus.o_ps2_clk_oe !== 1'b1 || bus.o_ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL nack_rts: clk_oe=%b data_oe=%b required 1 1", bus.o_ps2_clk_oe, bus.o_ps2_data_oe);
    end
    tick();
    for (int k = 1; k <= 10; k++) begin
      gap();
      pulse_edge(1'b1);
      checks++;
      if (bus.o_ps2_data_oe !== 1'b0) begin
        errors++; $display("FAIL nack_bit edge %0d: data_oe=%b required 0", k, bus.o_ps2_data_oe);
      end
    end
    pulse_edge(1'b1);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_ack_ok !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL nack_done: done=%b ack_ok=%b busy=%b required 1 0 0", bus.o_done, bus.o_ack_ok, bus.o_busy);
    end
    tick();
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    logic       ack;
    for (int f = 0; f < 6; f++) begin
      d   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      issue_start(d);
      repeat (9) tick();
      checks++;
      if (bus.o_ps2_clk_oe !== 1'b0 || bus.o_ps2_data_oe !== 1'b1 || bus.o_busy !== 1'b1) begin
        errors++; $display("FAIL rand_start byte %h: clk_oe=%b data_oe=%b busy=%b", d, bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy);
      end
      for (int k = 1; k <= 10; k++) begin
        gap();
        pulse_edge(1'b1);
        checks++;
        if (bus.o_ps2_data_oe !== exp_oe(d, k)) begin
          errors++; $display("FAIL rand_bit byte %h edge %0d: data_oe=%b required %b", d, k, bus.o_ps2_data_oe, exp_oe(d, k));
        end
      end
      gap();
      pulse_edge(~ack);
      checks++;
      if (bus.o_done !== 1'b1 || bus.o_ack_ok !== ack) begin
        errors++; $display("FAIL rand_ack byte %h: done=%b ack_ok=%b required 1 %b", d, bus.o_done, bus.o_ack_ok, ack);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    issue_start(PS2_CMD_ENABLE);
    repeat (3) tick();
    bus.i_start = 1'b1;
    bus.i_data  = 8'h00;
    tick();
    bus.i_start = 1'b0;
    repeat (5) tick();
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin
        bus.i_start = 1'b1;
        bus.i_data  = 8'h00;
      end
      pulse_edge(1'b1);
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_ps2_data_oe !== exp_oe(PS2_CMD_ENABLE, k)) begin
        errors++; $display("FAIL ignore_bit edge %0d: data_oe=%b required %b", k, bus.o_ps2_data_oe, exp_oe(PS2_CMD_ENABLE, k));
      end
    end
    pulse_edge(1'b0);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_ack_ok !== 1'b1) begin
      errors++; $display("FAIL ignore_done: done=%b ack_ok=%b required 1 1", bus.o_done, bus.o_ack_ok);
    end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_extra_activity: %0d busy/done cycles, required 0", extra);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int n;
    int saw_done;
    d = 8'($urandom);
    issue_start(d);
    repeat (9) tick();
    for (int k = 1; k <= 4; k++) begin
      gap();
      pulse_edge(1'b1);
      checks++;
      if (bus.o_ps2_data_oe !== exp_oe(d, k)) begin
        errors++; $display("FAIL timeout_bit edge %0d: data_oe=%b required %b", k, bus.o_ps2_data_oe, exp_oe(d, k));
      end
    end
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    saw_done = 0;
    while (bus.o_err !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus.o_done === 1'b1) saw_done++;
    end
    checks++;
    if (n !== TMO) begin
      errors++; $display("FAIL timeout_delay: err after %0d cycles, required %0d", n, TMO);
    end
    checks++;
    if (bus.o_ps2_clk_oe !== 1'b0 || bus.o_ps2_data_oe !== 1'b0 || bus.o_busy !== 1'b0 || saw_done !== 0) begin
      errors++; $display("FAIL timeout_abort: clk_oe=%b data_oe=%b busy=%b done_seen=%0d", bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy, saw_done);
    end
    tick();
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++; $display("FAIL timeout_err_pulse: err=%b required 0", bus.o_err);
    end
`else
    n = 0;
    saw_done = 0;
    for (int c = 0; c < 3 * TMO; c++) begin
      tick();
      if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL no_watchdog_wait: %0d cycles with err or idle, required 0", n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_ps2_data_oe !== 1'b0 || saw_done !== 0) begin
      errors++; $display("FAIL no_watchdog_recover: busy=%b data_oe=%b required 0 0", bus.o_busy, bus.o_ps2_data_oe);
    end
`endif
  endtask

  task automatic test_reset_mid();
    issue_start(PS2_CMD_RESET);
    repeat (9) tick();
    for (int k = 1; k <= 5; k++) pulse_edge(1'b1);
    bus.i_ps2_clk_neg = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_ps2_clk_oe !== 1'b0 || bus.o_ps2_data_oe !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: clk_oe=%b data_oe=%b busy=%b required 0 0 0", bus.o_ps2_clk_oe, bus.o_ps2_data_oe, bus.o_busy);
    end
    tick();
    rst = 1'b0;
    bus.i_ps2_clk_neg = 1'b0;
    tick();
    issue_start(PS2_CMD_RESET);
    repeat (9) tick();
    for (int k = 1; k <= 10; k++) begin
      gap();
      pulse_edge(1'b1);
      checks++;
      if (bus.o_ps2_data_oe !== exp_oe(PS2_CMD_RESET, k)) begin
        errors++; $display("FAIL reset_mid_resend edge %0d: data_oe=%b required %b", k, bus.o_ps2_data_oe, exp_oe(PS2_CMD_RESET, k));
      end
    end
    pulse_edge(1'b0);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_ack_ok !== 1'b1) begin
      errors++; $display("FAIL reset_mid_done: done=%b ack_ok=%b required 1 1", bus.o_done, bus.o_ack_ok);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1;
    logic [7:0] d2;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    issue_start(d1);
    repeat (9) tick();
    for (int k = 1; k <= 10; k++) pulse_edge(1'b1);
    pulse_edge(1'b0);
    checks++;
    if (bus.o_done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done: done=%b required 1", bus.o_done);
    end
    issue_start(d2);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_ps2_clk_oe !== 1'b1 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b clk_oe=%b done=%b required 1 1 0", bus.o_busy, bus.o_ps2_clk_oe, bus.o_done);
    end
    repeat (9) tick();
    for (int k = 1; k <= 10; k++) begin
      gap();
      pulse_edge(1'b1);
      checks++;
      if (bus.o_ps2_data_oe !== exp_oe(d2, k)) begin
        errors++; $display("FAIL b2b_bit byte %h edge %0d: data_oe=%b required %b", d2, k, bus.o_ps2_data_oe, exp_oe(d2, k));
      end
    end
    pulse_edge(1'b0);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_ack_ok !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done: done=%b ack_ok=%b busy=%b required 1 1 0", bus.o_done, bus.o_ack_ok, bus.o_busy);
    end
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_start       = 1'b0;
    bus.i_data        = 8'h00;
    bus.i_ps2_clk_neg = 1'b0;
    bus.i_ps2_data    = 1'b1;
    test_reset();
    test_send_enable();
    test_send_reset_nack();
    test_random_frames();
    test_start_ignored();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
